// File: rtl/dcf77_encoder_pkg.sv
// Shared types and constants for the DCF77 time-code encoder: date/time record,
// frame bit positions, pulse widths and the frame assembly helper.
package dcf77_encoder_pkg;

    typedef logic [3:0] bcd_t;

    typedef logic [58:0] dcf77_frame_t;

    typedef enum logic {
        TB_IDLE = 1'b0,
        TB_RUN  = 1'b1
    } tb_state_t;

    typedef struct packed {
        logic [13:0] broadcast;
        logic        r;
        logic        a1;
        logic        z1;
        logic        z2;
        logic        a2;
        bcd_t        min_ones;
        logic [2:0]  min_tens;
        logic        p1;
        bcd_t        hour_ones;
        logic [1:0]  hour_tens;
        logic        p2;
        bcd_t        day_ones;
        logic [1:0]  day_tens;
        logic [2:0]  dow;
        bcd_t        month_ones;
        logic        month_tens;
        bcd_t        year_ones;
        bcd_t        year_tens;
        logic        p3;
    } if_date_time_t;

    localparam int DCF_SECONDS      = 60;
    localparam int DCF_CS_PER_SEC   = 100;
    localparam int DCF_PULSE0_CS    = 10;
    localparam int DCF_PULSE1_CS    = 20;

    localparam int DCF_BIT_MINUTE   = 0;
    localparam int DCF_BIT_CIVIL_LO = 1;
    localparam int DCF_BIT_R        = 15;
    localparam int DCF_BIT_A1       = 16;
    localparam int DCF_BIT_Z1       = 17;
    localparam int DCF_BIT_Z2       = 18;
    localparam int DCF_BIT_A2       = 19;
    localparam int DCF_BIT_START    = 20;
    localparam int DCF_BIT_MIN_LO   = 21;
    localparam int DCF_BIT_P1       = 28;
    localparam int DCF_BIT_HOUR_LO  = 29;
    localparam int DCF_BIT_P2       = 35;
    localparam int DCF_BIT_DAY_LO   = 36;
    localparam int DCF_BIT_DOW_LO   = 42;
    localparam int DCF_BIT_MONTH_LO = 45;
    localparam int DCF_BIT_YEAR_LO  = 50;
    localparam int DCF_BIT_P3       = 58;

    // Parity bits are copied from dt here; the encoder may overwrite them.
    function automatic dcf77_frame_t build_frame(input if_date_time_t dt);
        dcf77_frame_t f;
        f = '0;
        f[DCF_BIT_MINUTE]             = 1'b0;
        f[DCF_BIT_CIVIL_LO +: 14]     = dt.broadcast;
        f[DCF_BIT_R]                  = dt.r;
        f[DCF_BIT_A1]                 = dt.a1;
        f[DCF_BIT_Z1]                 = dt.z1;
        f[DCF_BIT_Z2]                 = dt.z2;
        f[DCF_BIT_A2]                 = dt.a2;
        f[DCF_BIT_START]              = 1'b1;
        f[DCF_BIT_MIN_LO +: 4]        = dt.min_ones;
        f[DCF_BIT_MIN_LO + 4 +: 3]    = dt.min_tens;
        f[DCF_BIT_P1]                 = dt.p1;
        f[DCF_BIT_HOUR_LO +: 4]       = dt.hour_ones;
        f[DCF_BIT_HOUR_LO + 4 +: 2]   = dt.hour_tens;
        f[DCF_BIT_P2]                 = dt.p2;
        f[DCF_BIT_DAY_LO +: 4]        = dt.day_ones;
        f[DCF_BIT_DAY_LO + 4 +: 2]    = dt.day_tens;
        f[DCF_BIT_DOW_LO +: 3]        = dt.dow;
        f[DCF_BIT_MONTH_LO +: 4]      = dt.month_ones;
        f[DCF_BIT_MONTH_LO + 4]       = dt.month_tens;
        f[DCF_BIT_YEAR_LO +: 4]       = dt.year_ones;
        f[DCF_BIT_YEAR_LO + 4 +: 4]   = dt.year_tens;
        f[DCF_BIT_P3]                 = dt.p3;
        return f;
    endfunction

endpackage

// File: rtl/dcf77_timebase.sv
// Timebase for the DCF77 encoder: clock prescaler to 10 ms ticks and a
// centisecond counter, with a strobe marking the start of each second.
module dcf77_timebase
    import dcf77_encoder_pkg::*;
#(
    parameter int CLKS_PER_10MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       tick10,
    output logic       sec_start,
    output logic [6:0] cs
);

    localparam int PW = (CLKS_PER_10MS > 2) ? $clog2(CLKS_PER_10MS) : 1;

    tb_state_t      state_q, state_d;
    logic [PW-1:0]  pres_q, pres_d;
    logic [6:0]     cs_q, cs_d;

    // The first enabled edge after idle is itself a second start, with counters at zero.
    always_comb begin
        tick10    = (state_q == TB_RUN) && (pres_q == PW'(CLKS_PER_10MS - 1));
        sec_start = en && ((state_q == TB_IDLE) ||
                           (tick10 && (cs_q == 7'(DCF_CS_PER_SEC - 1))));
        state_d   = state_q;
        pres_d    = pres_q;
        cs_d      = cs_q;
        if (!en) begin
            state_d = TB_IDLE;
            pres_d  = '0;
            cs_d    = '0;
        end else if (state_q == TB_IDLE) begin
            state_d = TB_RUN;
            pres_d  = '0;
            cs_d    = '0;
        end else begin
            pres_d = tick10 ? '0 : pres_q + 1'b1;
            if (tick10) begin
                cs_d = (cs_q == 7'(DCF_CS_PER_SEC - 1)) ? 7'd0 : cs_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TB_IDLE;
            pres_q  <= '0;
            cs_q    <= '0;
        end else begin
            state_q <= state_d;
            pres_q  <= pres_d;
            cs_q    <= cs_d;
        end
    end

    assign cs = cs_q;

endmodule

// File: rtl/dcf77_encoder.sv
// DCF77 time-code pulse generator: latches a minute frame from dt at second 0
// and emits 100/200 ms pulses per bit. Define DCF77_ENC_PARITY_EN to compute p1/p2/p3.
module dcf77_encoder
    import dcf77_encoder_pkg::*;
#(
    parameter int CLKS_PER_10MS = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  if_date_time_t dt,
    output logic          dcf_out,
    output logic          sec_tick,
    output logic          minute_req,
    output logic [5:0]    second
);

    logic         tick10;
    logic         sec_start;
    logic [6:0]   cs;

    dcf77_timebase #(
        .CLKS_PER_10MS(CLKS_PER_10MS)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tick10    (tick10),
        .sec_start (sec_start),
        .cs        (cs)
    );

    dcf77_frame_t frame_q, frame_d;
    dcf77_frame_t new_frame;
    logic [5:0]   second_q, second_d;
    logic         dcf_out_q, dcf_out_d;
    logic         sec_tick_q, sec_tick_d;
    logic         minute_req_q, minute_req_d;
    logic         new_minute;
    logic         cur_bit;
    logic [6:0]   pulse_cs;

    always_comb begin
        new_frame = build_frame(dt);
`ifdef DCF77_ENC_PARITY_EN
        new_frame[DCF_BIT_P1] = ^new_frame[DCF_BIT_MIN_LO +: 7];
        new_frame[DCF_BIT_P2] = ^new_frame[DCF_BIT_HOUR_LO +: 6];
        new_frame[DCF_BIT_P3] = ^new_frame[DCF_BIT_DAY_LO +: 22];
`else
        new_frame[DCF_BIT_P1] = dt.p1;
        new_frame[DCF_BIT_P2] = dt.p2;
        new_frame[DCF_BIT_P3] = dt.p3;
`endif
    end

    // A second start without a tick10 is a fresh start from idle, which also begins a minute.
    always_comb begin
        new_minute   = sec_start && (!tick10 || (second_q == 6'(DCF_SECONDS - 1)));
        cur_bit      = (second_q < 6'(DCF_SECONDS - 1)) ? frame_q[second_q] : 1'b0;
        pulse_cs     = cur_bit ? 7'(DCF_PULSE1_CS) : 7'(DCF_PULSE0_CS);
        frame_d      = frame_q;
        second_d     = second_q;
        dcf_out_d    = dcf_out_q;
        sec_tick_d   = 1'b0;
        minute_req_d = 1'b0;
        if (!en) begin
            second_d  = '0;
            dcf_out_d = 1'b0;
        end else if (sec_start) begin
            sec_tick_d = 1'b1;
            if (new_minute) begin
                second_d = '0;
                frame_d  = new_frame;
            end else begin
                second_d = second_q + 6'd1;
            end
            minute_req_d = (second_d == 6'(DCF_SECONDS - 1));
            dcf_out_d    = (second_d != 6'(DCF_SECONDS - 1));
        end else if (tick10 && ((cs + 7'd1) == pulse_cs)) begin
            dcf_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q      <= '0;
            second_q     <= '0;
            dcf_out_q    <= 1'b0;
            sec_tick_q   <= 1'b0;
            minute_req_q <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            second_q     <= second_d;
            dcf_out_q    <= dcf_out_d;
            sec_tick_q   <= sec_tick_d;
            minute_req_q <= minute_req_d;
        end
    end

    assign dcf_out    = dcf_out_q;
    assign sec_tick   = sec_tick_q;
    assign minute_req = minute_req_q;
    assign second     = second_q;

endmodule
